// File: rtl/periph_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin peripheral arbiter.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  localparam int TO_CNT_W = 8;
  localparam logic [TO_CNT_W-1:0] TO_CNT_MAX = '1;

  // Counter width for values 0..n-1; never below one bit so degenerate
  // parameter values still yield a legal vector.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/periph_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around, so the last grantee gets lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  // Scan farthest-first so the nearest candidate after ptr is assigned last.
  always_comb begin
    o_idx  = '0;
    o_any  = |i_req;
    w_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/periph_rr_arbiter.sv
// Round-robin sequencer sharing one transaction engine among NREQ requesters:
// grant, start, wait for done or watchdog, enforce a gap, re-arbitrate.
module periph_rr_arbiter
  import periph_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int GAP_CYC     = 2
) (
  input  logic                    clk_100MHz,
  input  logic                    sysreset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    owner_vld,
  output logic                    eng_start,
  input  logic                    eng_busy,
  input  logic                    eng_done,
  output logic                    eng_abort,
  output logic                    timeout,
  output logic [TO_CNT_W-1:0]     timeout_cnt
);

  localparam int OW = $clog2(NREQ);
  localparam int TW = cw(TIMEOUT_CYC);
  localparam int GW = cw(GAP_CYC + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  arb_state_e          r_state;
  logic [NREQ-1:0]     r_gnt;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_ptr;
  logic [TW-1:0]       r_timer;
  logic [GW-1:0]       r_gap;
  logic [TO_CNT_W-1:0] r_to_cnt;

  logic [OW-1:0]       w_win;
  logic                w_any;
  logic                w_own_req;
  logic                w_start;
  logic                w_tmo;

  rr_pick #(.NREQ(NREQ), .IW(OW)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_own_req = req[r_owner];
  // Start only once the engine is free and the owner still wants the slot.
  assign w_start   = (r_state == ST_GRANT) && !eng_busy && w_own_req;
  // A done arriving on the last watchdog cycle wins over the abort.
  assign w_tmo     = (r_state == ST_WAIT) && !eng_done && (r_timer == TMAX);

  assign gnt         = r_gnt;
  assign owner       = r_owner;
  assign owner_vld   = |r_gnt;
  assign eng_start   = w_start;
  assign eng_abort   = w_tmo;
  assign timeout     = w_tmo;
  assign timeout_cnt = r_to_cnt;

  // Arbitration FSM with watchdog timer, gap counter and saturating timeout count.
  always_ff @(posedge clk_100MHz) begin
    if (sysreset) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_ptr    <= OW'(NREQ - 1);
      r_timer  <= '0;
      r_gap    <= '0;
      r_to_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_ptr   <= w_win;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_own_req) begin
            r_gnt   <= '0;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end else if (!eng_busy) begin
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (eng_done || (r_timer == TMAX)) begin
            r_gnt   <= '0;
            r_timer <= '0;
            r_gap   <= '0;
            r_state <= ST_GAP;
            if (w_tmo && (r_to_cnt != TO_CNT_MAX)) r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_GAP: begin
          if ((GAP_CYC == 0) || (r_gap == GLAST)) r_state <= ST_IDLE;
          else                                    r_gap   <= r_gap + GW'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Directed bench for periph_rr_arbiter: expected grants go into a scoreboard
// queue as stimulus is set up and are popped when the DUT asserts gnt.
module tb_periph_rr_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam int GAP  = 2;

  logic       clk_100MHz = 1'b0;
  logic       sysreset   = 1'b1;
  logic [3:0] req        = 4'b1111;
  logic       eng_busy   = 1'b0;
  logic       eng_done   = 1'b0;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       owner_vld, eng_start, eng_abort, timeout;
  logic [7:0] timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb[$];

  always #5 clk_100MHz = ~clk_100MHz;

  periph_rr_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .clk_100MHz (clk_100MHz),
    .sysreset   (sysreset),
    .req        (req),
    .gnt        (gnt),
    .owner      (owner),
    .owner_vld  (owner_vld),
    .eng_start  (eng_start),
    .eng_busy   (eng_busy),
    .eng_done   (eng_done),
    .eng_abort  (eng_abort),
    .timeout    (timeout),
    .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Wait (bounded) for a grant, then pop the scoreboard and compare.
  task automatic wait_gnt(output int w);
    logic [3:0] exp;
    int idx;
    w = 0;
    while (gnt == 4'b0 && w < 60) begin
      nxt();
      w++;
    end
    exp = sb.pop_front();
    idx = 0;
    for (int i = 0; i < NREQ; i++) if (exp[i]) idx = i;
    chk("gnt", 32'(gnt), 32'(exp));
    chk("owner", 32'(owner), 32'(idx));
    chk("owner_vld", 32'(owner_vld), 32'd1);
  endtask

  initial begin
    int w;
    int k;

    // Reset with every requester active: nothing may leak out.
    repeat (3) nxt();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_vld", 32'(owner_vld), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_abort", 32'(eng_abort), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_tocnt", 32'(timeout_cnt), 32'd0);
    sysreset = 1'b0;

    // Rotation with done 5 cycles after each start; grant gap is 3 low cycles.
    for (int t = 0; t < 5; t++) begin
      sb.push_back(4'b0001 << (t % 4));
      wait_gnt(w);
      chk("gnt_latency", 32'(w), (t == 0) ? 32'd1 : 32'd3);
      chk("rot_start", 32'(eng_start), 32'd1);
      repeat (5) begin
        nxt();
        chk("rot_nostart", 32'(eng_start), 32'd0);
      end
      eng_done = 1'b1;
      nxt();
      eng_done = 1'b0;
    end

    // Busy hold: start pulses only once busy drops.
    eng_busy = 1'b1;
    sb.push_back(4'b0010);
    wait_gnt(w);
    chk("busy_start0", 32'(eng_start), 32'd0);
    repeat (3) begin
      nxt();
      chk("busy_hold", 32'(eng_start), 32'd0);
      chk("busy_gnt", 32'(gnt), 32'b0010);
    end
    nxt();
    eng_busy = 1'b0;
    #1;
    chk("busy_start1", 32'(eng_start), 32'd1);
    nxt();
    chk("busy_single", 32'(eng_start), 32'd0);
    eng_done = 1'b1;
    nxt();
    eng_done = 1'b0;

    // Watchdog: abort 16 cycles after the start cycle.
    sb.push_back(4'b0100);
    wait_gnt(w);
    chk("to_start", 32'(eng_start), 32'd1);
    for (int i = 1; i < TO; i++) begin
      nxt();
      chk("to_early", 32'(eng_abort), 32'd0);
    end
    nxt();
    chk("to_abort", 32'(eng_abort), 32'd1);
    chk("to_pulse", 32'(timeout), 32'd1);
    nxt();
    chk("to_abort_end", 32'(eng_abort), 32'd0);
    chk("to_cnt1", 32'(timeout_cnt), 32'd1);
    chk("to_gnt_off", 32'(gnt), 32'd0);

    // Done on the final watchdog cycle beats the timeout.
    sb.push_back(4'b1000);
    wait_gnt(w);
    chk("to_next_lat", 32'(w), 32'd3);
    chk("tie_start", 32'(eng_start), 32'd1);
    repeat (TO - 1) nxt();
    nxt();
    eng_done = 1'b1;
    #1;
    chk("tie_abort", 32'(eng_abort), 32'd0);
    chk("tie_timeout", 32'(timeout), 32'd0);
    nxt();
    eng_done = 1'b0;
    chk("tie_cnt", 32'(timeout_cnt), 32'd1);
    chk("tie_gnt_off", 32'(gnt), 32'd0);

    // Cancel: owner drops request while engine busy.
    req      = 4'b0100;
    eng_busy = 1'b1;
    sb.push_back(4'b0100);
    wait_gnt(w);
    chk("cx_start0", 32'(eng_start), 32'd0);
    req = 4'b0000;
    #1;
    chk("cx_start1", 32'(eng_start), 32'd0);
    nxt();
    chk("cx_gnt_off", 32'(gnt), 32'd0);
    chk("cx_vld_off", 32'(owner_vld), 32'd0);
    chk("cx_owner_hold", 32'(owner), 32'd2);
    req      = 4'b0001;
    eng_busy = 1'b0;
    sb.push_back(4'b0001);
    wait_gnt(w);
    chk("cx_gap_lat", 32'(w), 32'd3);
    chk("cx_next_start", 32'(eng_start), 32'd1);
    repeat (2) nxt();
    eng_done = 1'b1;
    nxt();
    eng_done = 1'b0;

    // Reset in WAIT: grant drops, no abort, counter cleared.
    req = 4'b1111;
    sb.push_back(4'b0010);
    wait_gnt(w);
    chk("mr_start", 32'(eng_start), 32'd1);
    repeat (3) nxt();
    sysreset = 1'b1;
    nxt();
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_vld", 32'(owner_vld), 32'd0);
    chk("mr_abort", 32'(eng_abort), 32'd0);
    chk("mr_cnt", 32'(timeout_cnt), 32'd0);
    sysreset = 1'b0;

    // 260 forced timeouts: counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      sb.push_back(4'b0001 << (i % 4));
      wait_gnt(w);
      if (i == 0) chk("sat_first_lat", 32'(w), 32'd1);
      k = 0;
      while (!eng_abort && k < 40) begin
        nxt();
        k++;
      end
      chk("sat_abort", 32'(eng_abort), 32'd1);
      if (i == 0) chk("sat_abort_dly", 32'(k), 32'd16);
      nxt();
      if (i == 9)   chk("sat_cnt10", 32'(timeout_cnt), 32'd10);
      if (i == 254) chk("sat_cnt255", 32'(timeout_cnt), 32'd255);
    end
    chk("sat_final", 32'(timeout_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

endmodule
